// File: rtl/alu_operand_stage.sv
// alu_operand_stage: operand-fetch stage in front of the 16-bit ALU.
// Holds the architectural register file, reads two sources per instruction
// with writeback write-through, tracks per-register pending writes to stall
// RAW/WAW hazards, and presents operands through a valid/ready register.
// Optional feature macro: ALU_OPSTAGE_IMM_EN enables the immediate operand B
// path; when undefined, in_use_imm/in_imm are ignored and B is always in_rb.
module alu_operand_stage #(
  parameter int INPUT_WIDTH = 16,
  parameter int REG_ADDR_W  = 3
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [3:0]             in_cop,
  input  logic [REG_ADDR_W-1:0]  in_ra,
  input  logic [REG_ADDR_W-1:0]  in_rb,
  input  logic [REG_ADDR_W-1:0]  in_rd,
  input  logic                   in_we,
  input  logic                   in_use_imm,
  input  logic [INPUT_WIDTH-1:0] in_imm,
  input  logic                   wb_en,
  input  logic [REG_ADDR_W-1:0]  wb_addr,
  input  logic [INPUT_WIDTH-1:0] wb_data,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [INPUT_WIDTH-1:0] reg_A,
  output logic [INPUT_WIDTH-1:0] reg_B,
  output logic [3:0]             cop,
  output logic [REG_ADDR_W-1:0]  out_rd,
  output logic                   out_we
);

  localparam int DEPTH = 1 << REG_ADDR_W;

  logic [INPUT_WIDTH-1:0] rf_q [DEPTH];
  logic [INPUT_WIDTH-1:0] rf_d [DEPTH];
  logic [DEPTH-1:0]       pending_q, pending_d;
  logic                   out_valid_q, out_valid_d;
  logic [INPUT_WIDTH-1:0] reg_a_q, reg_a_d;
  logic [INPUT_WIDTH-1:0] reg_b_q, reg_b_d;
  logic [3:0]             cop_q, cop_d;
  logic [REG_ADDR_W-1:0]  out_rd_q, out_rd_d;
  logic                   out_we_q, out_we_d;

  logic                   use_imm;
  logic [DEPTH-1:0]       wb_mask;
  logic [DEPTH-1:0]       set_mask;
  logic [DEPTH-1:0]       eff_pend;
  logic [INPUT_WIDTH-1:0] opnd_a, opnd_rb, opnd_b;
  logic                   hazard;
  logic                   accept;

`ifdef ALU_OPSTAGE_IMM_EN
  assign use_imm = in_use_imm;
`else
  // Immediate path compiled out; ports stay for drop-in compatibility.
  logic unused_imm;
  assign unused_imm = ^{in_use_imm, in_imm};
  assign use_imm    = 1'b0;
`endif

  // Decode writeback and issue-time destination into one-hot register masks.
  always_comb begin
    wb_mask  = '0;
    set_mask = '0;
    if (wb_en) wb_mask[wb_addr] = 1'b1;
    if (accept && in_we) set_mask[in_rd] = 1'b1;
  end

  assign eff_pend = pending_q & ~wb_mask;

  // Source reads with same-cycle writeback forwarding.
  always_comb begin
    opnd_a  = (wb_en && (wb_addr == in_ra)) ? wb_data : rf_q[in_ra];
    opnd_rb = (wb_en && (wb_addr == in_rb)) ? wb_data : rf_q[in_rb];
`ifdef ALU_OPSTAGE_IMM_EN
    opnd_b  = use_imm ? in_imm : opnd_rb;
`else
    opnd_b  = opnd_rb;
`endif
  end

  // Hazard detection against pending writes, after this cycle's retirement.
  always_comb begin
    hazard = in_valid && (eff_pend[in_ra] ||
                          (!use_imm && eff_pend[in_rb]) ||
                          (in_we && eff_pend[in_rd]));
  end

  assign in_ready = (!out_valid_q || out_ready) && !hazard;
  assign accept   = in_valid && in_ready;

  // Next state of register file and scoreboard; issue set overrides wb clear.
  always_comb begin
    rf_d = rf_q;
    if (wb_en) rf_d[wb_addr] = wb_data;
    pending_d = eff_pend | set_mask;
  end

  // Next state of the output pipeline register.
  always_comb begin
    out_valid_d = out_valid_q;
    reg_a_d     = reg_a_q;
    reg_b_d     = reg_b_q;
    cop_d       = cop_q;
    out_rd_d    = out_rd_q;
    out_we_d    = out_we_q;
    if (accept) begin
      out_valid_d = 1'b1;
      reg_a_d     = opnd_a;
      reg_b_d     = opnd_b;
      cop_d       = in_cop;
      out_rd_d    = in_rd;
      out_we_d    = in_we;
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  // State registers; reset also discards any writeback in the same cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      rf_q        <= '{default: '0};
      pending_q   <= '0;
      out_valid_q <= 1'b0;
      reg_a_q     <= '0;
      reg_b_q     <= '0;
      cop_q       <= '0;
      out_rd_q    <= '0;
      out_we_q    <= 1'b0;
    end else begin
      rf_q        <= rf_d;
      pending_q   <= pending_d;
      out_valid_q <= out_valid_d;
      reg_a_q     <= reg_a_d;
      reg_b_q     <= reg_b_d;
      cop_q       <= cop_d;
      out_rd_q    <= out_rd_d;
      out_we_q    <= out_we_d;
    end
  end

  assign out_valid = out_valid_q;
  assign reg_A     = reg_a_q;
  assign reg_B     = reg_b_q;
  assign cop       = cop_q;
  assign out_rd    = out_rd_q;
  assign out_we    = out_we_q;

endmodule

// File: tb/tb_alu_operand_stage.sv
// Testbench for alu_operand_stage: directed vectors, expected outputs queued
// at issue and checked by an independent monitor on the falling edge.
module tb_alu_operand_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  in_cop;
  logic [2:0]  in_ra, in_rb, in_rd;
  logic        in_we;
  logic        in_use_imm;
  logic [15:0] in_imm;
  logic        wb_en;
  logic [2:0]  wb_addr;
  logic [15:0] wb_data;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] reg_A, reg_B;
  logic [3:0]  cop;
  logic [2:0]  out_rd;
  logic        out_we;

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic [3:0]  c;
    logic [2:0]  rd;
    logic        we;
  } exp_t;

  exp_t exp_q[$];
  int   n_chk = 0;
  int   n_err = 0;

  alu_operand_stage #(.INPUT_WIDTH(16), .REG_ADDR_W(3)) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready), .in_cop(in_cop),
    .in_ra(in_ra), .in_rb(in_rb), .in_rd(in_rd), .in_we(in_we),
    .in_use_imm(in_use_imm), .in_imm(in_imm),
    .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data),
    .out_valid(out_valid), .out_ready(out_ready),
    .reg_A(reg_A), .reg_B(reg_B), .cop(cop), .out_rd(out_rd), .out_we(out_we)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exv);
    n_chk++;
    if (act !== exv) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exv);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [15:0] a, input logic [15:0] b, input logic [3:0] c,
                      input logic [2:0] rd, input logic we);
    exp_t e;
    e.a = a; e.b = b; e.c = c; e.rd = rd; e.we = we;
    exp_q.push_back(e);
  endtask

  task automatic issue(input logic [3:0] c, input logic [2:0] a, input logic [2:0] b,
                       input logic [2:0] d, input logic w, input logic ui,
                       input logic [15:0] im, input logic exp_rdy, input string nm);
    in_valid = 1'b1; in_cop = c; in_ra = a; in_rb = b; in_rd = d; in_we = w;
    in_use_imm = ui; in_imm = im;
    #1 chk(nm, in_ready, exp_rdy);
  endtask

  // Output monitor: compare head of expected queue while valid, pop on handshake.
  always @(negedge clk) begin
    if (!reset && out_valid) begin
      if (exp_q.size() == 0) begin
        n_chk++;
        n_err++;
        $display("FAIL unexpected_out: got out_valid=1 expected no output (cop=%0h)", cop);
      end else begin
        chk("out_reg_A", reg_A, exp_q[0].a);
        chk("out_reg_B", reg_B, exp_q[0].b);
        chk("out_cop", cop, exp_q[0].c);
        chk("out_rd", out_rd, exp_q[0].rd);
        chk("out_we", out_we, exp_q[0].we);
        if (out_ready) void'(exp_q.pop_front());
      end
    end
  end

  initial begin
    logic imm_rdy;
`ifdef ALU_OPSTAGE_IMM_EN
    imm_rdy = 1'b1;
`else
    imm_rdy = 1'b0;
`endif
    reset = 1'b1; in_valid = 1'b0; in_cop = '0; in_ra = '0; in_rb = '0; in_rd = '0;
    in_we = 1'b0; in_use_imm = 1'b0; in_imm = '0;
    wb_en = 1'b0; wb_addr = '0; wb_data = '0; out_ready = 1'b1;
    repeat (2) cyc();
    reset = 1'b0;
    #1;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_reg_A", reg_A, 0);
    chk("rst_reg_B", reg_B, 0);
    chk("rst_cop", cop, 0);
    chk("rst_out_rd_we", {out_rd, out_we}, 0);
    chk("rst_in_ready", in_ready, 1);
    cyc();

    // Load R1=5, R2=3 through writeback.
    wb_en = 1'b1; wb_addr = 3'd1; wb_data = 16'h0005; cyc();
    wb_addr = 3'd2; wb_data = 16'h0003; cyc();
    wb_en = 1'b0;

    // Basic issue: R3 <- op(R1, R2).
    issue(4'h1, 3'd1, 3'd2, 3'd3, 1'b1, 1'b0, 16'h0, 1'b1, "basic_ready");
    push(16'h0005, 16'h0003, 4'h1, 3'd3, 1'b1);
    cyc();

    // RAW on pending R3 stalls until its writeback, which forwards.
    issue(4'h2, 3'd3, 3'd1, 3'd5, 1'b0, 1'b0, 16'h0, 1'b0, "raw_stall");
    cyc();
    #1 chk("raw_stall2", in_ready, 0);
    cyc();
    wb_en = 1'b1; wb_addr = 3'd3; wb_data = 16'h0008;
    #1 chk("raw_wb_release", in_ready, 1);
    push(16'h0008, 16'h0005, 4'h2, 3'd5, 1'b0);
    cyc();
    wb_en = 1'b0;
    issue(4'h3, 3'd3, 3'd3, 3'd6, 1'b1, 1'b0, 16'h0, 1'b1, "raw_cleared");
    push(16'h0008, 16'h0008, 4'h3, 3'd6, 1'b1);
    cyc();
    in_valid = 1'b0;

    // Backpressure: hold output 3 cycles, then release.
    issue(4'h4, 3'd1, 3'd2, 3'd7, 1'b0, 1'b0, 16'h0, 1'b1, "bp_first");
    push(16'h0005, 16'h0003, 4'h4, 3'd7, 1'b0);
    cyc();
    out_ready = 1'b0;
    issue(4'h5, 3'd2, 3'd1, 3'd0, 1'b0, 1'b0, 16'h0, 1'b0, "bp_stall");
    cyc();
    #1 chk("bp_stall2", in_ready, 0);
    cyc();
    #1 chk("bp_stall3", in_ready, 0);
    cyc();
    out_ready = 1'b1;
    #1 chk("bp_release", in_ready, 1);
    push(16'h0003, 16'h0005, 4'h5, 3'd0, 1'b0);
    cyc();
    in_valid = 1'b0;
    cyc();

    // Immediate for B with rb naming pending R6.
    issue(4'h6, 3'd1, 3'd6, 3'd2, 1'b0, 1'b1, 16'hFFFF, imm_rdy, "imm_hazard");
    if (imm_rdy) push(16'h0005, 16'hFFFF, 4'h6, 3'd2, 1'b0);
    cyc();
    in_valid = 1'b0; in_use_imm = 1'b0;
    wb_en = 1'b1; wb_addr = 3'd6; wb_data = 16'h1234;
    cyc();
    wb_en = 1'b0;

    // Same-cycle set and clear on R4: set wins.
    issue(4'h7, 3'd1, 3'd1, 3'd4, 1'b1, 1'b0, 16'h0, 1'b1, "sc_first");
    push(16'h0005, 16'h0005, 4'h7, 3'd4, 1'b1);
    cyc();
    wb_en = 1'b1; wb_addr = 3'd4; wb_data = 16'h00AA;
    issue(4'h8, 3'd4, 3'd1, 3'd4, 1'b1, 1'b0, 16'h0, 1'b1, "set_clear");
    push(16'h00AA, 16'h0005, 4'h8, 3'd4, 1'b1);
    cyc();
    wb_en = 1'b0;
    issue(4'h9, 3'd4, 3'd1, 3'd0, 1'b0, 1'b0, 16'h0, 1'b0, "set_wins");
    cyc();
    in_valid = 1'b0;

    // Reset with a held output and pending R2; wb in reset cycle is dropped.
    issue(4'hA, 3'd1, 3'd1, 3'd2, 1'b1, 1'b0, 16'h0, 1'b1, "pre_reset");
    push(16'h0005, 16'h0005, 4'hA, 3'd2, 1'b1);
    cyc();
    in_valid = 1'b0; out_ready = 1'b0; reset = 1'b1;
    wb_en = 1'b1; wb_addr = 3'd2; wb_data = 16'h7777;
    cyc();
    wb_en = 1'b0; reset = 1'b0;
    exp_q.delete();
    #1;
    chk("post_reset_valid", out_valid, 0);
    chk("post_reset_ready", in_ready, 1);
    out_ready = 1'b1;
    issue(4'hB, 3'd2, 3'd4, 3'd4, 1'b1, 1'b0, 16'h0, 1'b1, "post_reset_pending");
    push(16'h0000, 16'h0000, 4'hB, 3'd4, 1'b1);
    cyc();
    in_valid = 1'b0;
    repeat (3) cyc();
    chk("drain_queue", exp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
